aes_blk_serializer: RTL and testbench

AES_BLK_SERIALIZER -- requirements
Module: aes_blk_serializer

---
 rtl/aes_blk_serializer_pkg.sv | 24 ++
 rtl/aes_blk_fifo.sv | 53 +++++
 rtl/aes_blk_serializer.sv | 127 ++++++++++++
 tb/tb_aes_blk_serializer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_blk_serializer_pkg.sv
// rtl/aes_blk_serializer_pkg.sv - shared AES block-size macros, serializer types and lane helper
`ifndef AES_VH
`define AES_VH
`define BLK_S 128
`define AES_BEATS(bus_w) (`BLK_S / (bus_w))
`endif

package aes_blk_serializer_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } ser_state_t;

   localparam int BLK_W  = `BLK_S;
   localparam int FIFO_W = BLK_W + 1;
   localparam int LANE_W = 32;

   // Reverse the four bytes of one 32-bit lane.
   function automatic logic [LANE_W-1:0] swap_lane(input logic [LANE_W-1:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// rtl/aes_blk_fifo.sv - block buffer holding {tlast, data} entries with wrap-bit pointers
module aes_blk_fifo
   import aes_blk_serializer_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = FIFO_W
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             empty,
   output logic             full,
   output logic             one_left
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;
   logic [AW:0]      count;

   // Storage and pointers; a push into a full buffer is only legal alongside a pop,
   // in which case it reuses the slot being released this cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wptr <= '0;
         rptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wptr[AW-1:0]] <= push_data;
            wptr              <= wptr + (AW+1)'(1);
         end
         if (pop) begin
            rptr <= rptr + (AW+1)'(1);
         end
      end
   end

   // The extra wrap bit makes the pointer difference span 0..DEPTH.
   assign count     = wptr - rptr;
   assign empty     = (count == '0);
   assign full      = (count == (AW+1)'(DEPTH));
   assign one_left  = (count == (AW+1)'(1));
   assign head_data = mem[rptr[AW-1:0]];

endmodule

// File: rtl/aes_blk_serializer.sv
// rtl/aes_blk_serializer.sv - splits buffered 128-bit AES blocks into bus beats; AES_OUT_BYTE_SWAP_EN byte-reverses each 32-bit lane
module aes_blk_serializer
   import aes_blk_serializer_pkg::*;
#(
   parameter int BUS_TDATA_WIDTH = 32,
   parameter int BUF_DEPTH       = 2
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       blk_tvalid,
   output logic                       blk_tready,
   input  logic [`BLK_S-1:0]          blk_tdata,
   input  logic                       blk_tlast,
   output logic                       bus_tvalid,
   input  logic                       bus_tready,
   output logic [BUS_TDATA_WIDTH-1:0] bus_tdata,
   output logic                       bus_tlast,
   output logic                       buf_empty
);

   localparam int BEATS = `AES_BEATS(BUS_TDATA_WIDTH);
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   ser_state_t           state;
   logic                 valid_q;
   logic                 rdy_en;
   logic [CNT_W-1:0]     beat_cnt;

   logic                 fifo_empty;
   logic                 fifo_full;
   logic                 fifo_one_left;
   logic [FIFO_W-1:0]    fifo_head;
   logic                 push;
   logic                 pop;
   logic                 final_beat;

   logic [BLK_W-1:0]           head_blk;
   logic                       head_last;
   logic [BLK_W-1:0]           shifted;
   logic [BUS_TDATA_WIDTH-1:0] beat_word;
   logic [BUS_TDATA_WIDTH-1:0] out_word;

   assign head_blk   = fifo_head[BLK_W-1:0];
   assign head_last  = fifo_head[BLK_W];
   assign final_beat = (beat_cnt == LAST_BEAT);

   // A block leaves the buffer only when its last beat handshakes, so a full
   // buffer can still take a new block in that same cycle.
   assign pop        = valid_q && bus_tready && final_beat;
   assign blk_tready = rdy_en && (!fifo_full || pop);
   assign push       = blk_tvalid && blk_tready;

   aes_blk_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (FIFO_W)
   ) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (push),
      .push_data ({blk_tlast, blk_tdata}),
      .pop       (pop),
      .head_data (fifo_head),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .one_left  (fifo_one_left)
   );

   // Serializer FSM: IDLE until a block is stored, SEND while beats remain; also
   // holds off blk_tready for the first cycle after reset release.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= ST_IDLE;
         valid_q  <= 1'b0;
         beat_cnt <= '0;
         rdy_en   <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (push) begin
                  state   <= ST_SEND;
                  valid_q <= 1'b1;
               end
            end
            ST_SEND: begin
               if (bus_tready) begin
                  if (final_beat) begin
                     beat_cnt <= '0;
                     if (fifo_one_left && !push) begin
                        state   <= ST_IDLE;
                        valid_q <= 1'b0;
                     end
                  end else begin
                     beat_cnt <= beat_cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
               state   <= ST_IDLE;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Select the current beat, most significant word first.
   always_comb begin
      shifted   = head_blk >> (BUS_TDATA_WIDTH * int'(LAST_BEAT - beat_cnt));
      beat_word = shifted[BUS_TDATA_WIDTH-1:0];
   end

`ifdef AES_OUT_BYTE_SWAP_EN
   for (genvar l = 0; l < BUS_TDATA_WIDTH / LANE_W; l++) begin : g_swap
      assign out_word[LANE_W*l +: LANE_W] = swap_lane(beat_word[LANE_W*l +: LANE_W]);
   end
`else
   assign out_word = beat_word;
`endif

   // Outputs are forced low whenever no beat is presented, including during reset.
   assign bus_tvalid = valid_q;
   assign bus_tdata  = valid_q ? out_word : '0;
   assign bus_tlast  = valid_q && final_beat && head_last;
   assign buf_empty  = fifo_empty;

endmodule

// File: tb/tb_aes_blk_serializer.sv
// tb/tb_aes_blk_serializer.sv - directed self-checking bench for aes_blk_serializer
module tb_aes_blk_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         resetn;
   logic         blk_tvalid, blk_tready, blk_tlast;
   logic [127:0] blk_tdata;
   logic         bus_tvalid, bus_tready, bus_tlast, buf_empty;
   logic [31:0]  bus_tdata;

   logic         w_blk_tvalid, w_blk_tready, w_blk_tlast;
   logic [127:0] w_blk_tdata;
   logic         w_bus_tvalid, w_bus_tready, w_bus_tlast, w_buf_empty;
   logic [63:0]  w_bus_tdata;

   int checks   = 0;
   int failures = 0;

   localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
   localparam logic [127:0] BLK_B = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
   localparam logic [127:0] BLK_C = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
   localparam logic [127:0] BLK_E = 128'hFFFFFFFF_FFFFFFFF_00000000_00000000;

   aes_blk_serializer #(.BUS_TDATA_WIDTH(32), .BUF_DEPTH(2)) u_dut (
      .clk(clk), .resetn(resetn),
      .blk_tvalid(blk_tvalid), .blk_tready(blk_tready), .blk_tdata(blk_tdata), .blk_tlast(blk_tlast),
      .bus_tvalid(bus_tvalid), .bus_tready(bus_tready), .bus_tdata(bus_tdata), .bus_tlast(bus_tlast),
      .buf_empty(buf_empty)
   );

   aes_blk_serializer #(.BUS_TDATA_WIDTH(64), .BUF_DEPTH(2)) u_dut64 (
      .clk(clk), .resetn(resetn),
      .blk_tvalid(w_blk_tvalid), .blk_tready(w_blk_tready), .blk_tdata(w_blk_tdata), .blk_tlast(w_blk_tlast),
      .bus_tvalid(w_bus_tvalid), .bus_tready(w_bus_tready), .bus_tdata(w_bus_tdata), .bus_tlast(w_bus_tlast),
      .buf_empty(w_buf_empty)
   );

   function automatic logic [127:0] swap_lanes(input logic [127:0] v);
      logic [127:0] r;
      for (int l = 0; l < 4; l++) begin
         r[32*l +: 32] = {v[32*l +: 8], v[32*l+8 +: 8], v[32*l+16 +: 8], v[32*l+24 +: 8]};
      end
      return r;
   endfunction

   // Expected beat idx of blk for a bus of width w (zero-extended to 128 bits).
   function automatic logic [127:0] exp_beat(input logic [127:0] blk, input int idx, input int w);
      logic [127:0] s;
      logic [127:0] m;
      s = blk >> (128 - w * (idx + 1));
      m = (w == 128) ? '1 : ((128'd1 << w) - 128'd1);
      s = s & m;
`ifdef AES_OUT_BYTE_SWAP_EN
      s = swap_lanes(s);
`endif
      return s;
   endfunction

   task automatic test_reset();
      resetn = 1'b0;
      blk_tvalid = 1'b0; blk_tdata = '0; blk_tlast = 1'b0; bus_tready = 1'b0;
      w_blk_tvalid = 1'b0; w_blk_tdata = '0; w_blk_tlast = 1'b0; w_bus_tready = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus_tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid got=%b exp=0", bus_tvalid); end
      checks++; if (bus_tlast !== 1'b0) begin failures++; $display("FAIL rst_tlast got=%b exp=0", bus_tlast); end
      checks++; if (bus_tdata !== 32'h0) begin failures++; $display("FAIL rst_tdata got=%h exp=0", bus_tdata); end
      checks++; if (blk_tready !== 1'b0) begin failures++; $display("FAIL rst_blk_tready got=%b exp=0", blk_tready); end
      checks++; if (buf_empty !== 1'b1) begin failures++; $display("FAIL rst_buf_empty got=%b exp=1", buf_empty); end
      resetn = 1'b1;
      #1;
      checks++; if (blk_tready !== 1'b0) begin failures++; $display("FAIL rel_blk_tready_early got=%b exp=0", blk_tready); end
      @(negedge clk); #1;
      checks++; if (blk_tready !== 1'b1) begin failures++; $display("FAIL rel_blk_tready got=%b exp=1", blk_tready); end
      checks++; if (w_blk_tready !== 1'b1) begin failures++; $display("FAIL rel_w_blk_tready got=%b exp=1", w_blk_tready); end
   endtask

   task automatic test_single_block();
      logic [127:0] e;
      @(negedge clk);
      blk_tvalid = 1'b1; blk_tdata = BLK_A; blk_tlast = 1'b1; bus_tready = 1'b1;
      #1;
      checks++; if (blk_tready !== 1'b1) begin failures++; $display("FAIL single_accept got=%b exp=1", blk_tready); end
      @(negedge clk);
      blk_tvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         e = exp_beat(BLK_A, i, 32);
         checks++; if (bus_tvalid !== 1'b1) begin failures++; $display("FAIL single_valid beat=%0d got=%b exp=1", i, bus_tvalid); end
         checks++; if (bus_tdata !== e[31:0]) begin failures++; $display("FAIL single_data beat=%0d got=%h exp=%h", i, bus_tdata, e[31:0]); end
         checks++; if (bus_tlast !== (i == 3)) begin failures++; $display("FAIL single_last beat=%0d got=%b exp=%b", i, bus_tlast, (i == 3)); end
         @(negedge clk);
      end
      #1;
      checks++; if (bus_tvalid !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", bus_tvalid); end
      checks++; if (buf_empty !== 1'b1) begin failures++; $display("FAIL single_empty got=%b exp=1", buf_empty); end
   endtask

   task automatic test_backpressure();
      logic [3:0]   pat;
      logic [127:0] e;
      logic [31:0]  held;
      logic         have_held;
      int           got;
      int           k;
      pat = 4'b1001;
      have_held = 1'b0; held = '0; got = 0; k = 0;
      @(negedge clk);
      bus_tready = 1'b0;
      blk_tvalid = 1'b1; blk_tdata = BLK_B; blk_tlast = 1'b0;
      @(negedge clk);
      blk_tvalid = 1'b0;
      while (got < 4 && k < 40) begin
         bus_tready = pat[k % 4];
         #1;
         if (bus_tvalid !== 1'b1) begin
            checks++; failures++; $display("FAIL bp_valid cycle=%0d got=%b exp=1", k, bus_tvalid);
         end else begin
            e = exp_beat(BLK_B, got, 32);
            if (have_held) begin
               checks++; if (bus_tdata !== held) begin failures++; $display("FAIL bp_stable cycle=%0d got=%h exp=%h", k, bus_tdata, held); end
            end
            checks++; if (bus_tdata !== e[31:0]) begin failures++; $display("FAIL bp_data beat=%0d got=%h exp=%h", got, bus_tdata, e[31:0]); end
            checks++; if (bus_tlast !== 1'b0) begin failures++; $display("FAIL bp_last beat=%0d got=%b exp=0", got, bus_tlast); end
            if (bus_tready) begin
               got++; have_held = 1'b0;
            end else begin
               held = bus_tdata; have_held = 1'b1;
            end
         end
         k++;
         @(negedge clk);
      end
      bus_tready = 1'b1;
      #1;
      checks++; if (got !== 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", got); end
      checks++; if (bus_tvalid !== 1'b0) begin failures++; $display("FAIL bp_extra_beat got=%b exp=0", bus_tvalid); end
   endtask

   task automatic test_full_buffer();
      logic [127:0] blks [3];
      logic         lasts [3];
      logic [127:0] e;
      int           got;
      int           accept_at;
      int           gaps;
      int           k;
      blks[0] = BLK_A; blks[1] = BLK_B; blks[2] = BLK_C;
      lasts[0] = 1'b0; lasts[1] = 1'b1; lasts[2] = 1'b1;
      bus_tready = 1'b0;
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         blk_tvalid = 1'b1; blk_tdata = blks[j]; blk_tlast = lasts[j];
         #1;
         checks++; if (blk_tready !== (j < 2)) begin failures++; $display("FAIL full_tready push=%0d got=%b exp=%b", j, blk_tready, (j < 2)); end
      end
      @(negedge clk); #1;
      checks++; if (blk_tready !== 1'b0) begin failures++; $display("FAIL full_hold got=%b exp=0", blk_tready); end
      e = exp_beat(BLK_A, 0, 32);
      checks++; if (bus_tdata !== e[31:0]) begin failures++; $display("FAIL full_stall_data got=%h exp=%h", bus_tdata, e[31:0]); end
      got = 0; accept_at = -1; gaps = 0; k = 0;
      while (got < 12 && k < 60) begin
         @(negedge clk);
         if (accept_at >= 0) blk_tvalid = 1'b0;
         bus_tready = 1'b1;
         #1;
         if (blk_tvalid && blk_tready) accept_at = got;
         if (bus_tvalid) begin
            e = exp_beat(blks[got / 4], got % 4, 32);
            checks++; if (bus_tdata !== e[31:0]) begin failures++; $display("FAIL full_data beat=%0d got=%h exp=%h", got, bus_tdata, e[31:0]); end
            checks++; if (bus_tlast !== (got == 7 || got == 11)) begin failures++; $display("FAIL full_last beat=%0d got=%b exp=%b", got, bus_tlast, (got == 7 || got == 11)); end
            got++;
         end else begin
            gaps++;
         end
         k++;
      end
      checks++; if (got !== 12) begin failures++; $display("FAIL full_count got=%0d exp=12", got); end
      checks++; if (gaps !== 0) begin failures++; $display("FAIL full_gaps got=%0d exp=0", gaps); end
      checks++; if (accept_at !== 3) begin failures++; $display("FAIL full_accept_beat got=%0d exp=3", accept_at); end
      @(negedge clk);
      blk_tvalid = 1'b0;
      #1;
      checks++; if (bus_tvalid !== 1'b0) begin failures++; $display("FAIL full_idle got=%b exp=0", bus_tvalid); end
      checks++; if (buf_empty !== 1'b1) begin failures++; $display("FAIL full_empty got=%b exp=1", buf_empty); end
   endtask

   task automatic test_reset_mid_block();
      logic [127:0] e;
      @(negedge clk);
      bus_tready = 1'b1;
      blk_tvalid = 1'b1; blk_tdata = BLK_B; blk_tlast = 1'b1;
      @(negedge clk);
      blk_tdata = BLK_C;
      @(negedge clk);
      blk_tvalid = 1'b0;
      @(negedge clk); #1;
      e = exp_beat(BLK_B, 2, 32);
      checks++; if (bus_tdata !== e[31:0]) begin failures++; $display("FAIL mid_pre_data got=%h exp=%h", bus_tdata, e[31:0]); end
      #1;
      resetn = 1'b0;
      #1;
      checks++; if (bus_tvalid !== 1'b0) begin failures++; $display("FAIL mid_async_valid got=%b exp=0", bus_tvalid); end
      checks++; if (bus_tdata !== 32'h0) begin failures++; $display("FAIL mid_async_data got=%h exp=0", bus_tdata); end
      checks++; if (blk_tready !== 1'b0) begin failures++; $display("FAIL mid_async_tready got=%b exp=0", blk_tready); end
      checks++; if (buf_empty !== 1'b1) begin failures++; $display("FAIL mid_async_empty got=%b exp=1", buf_empty); end
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      blk_tvalid = 1'b1; blk_tdata = BLK_E; blk_tlast = 1'b1;
      #1;
      checks++; if (blk_tready !== 1'b1) begin failures++; $display("FAIL mid_accept got=%b exp=1", blk_tready); end
      @(negedge clk);
      blk_tvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         e = exp_beat(BLK_E, i, 32);
         checks++; if (bus_tvalid !== 1'b1) begin failures++; $display("FAIL mid_valid beat=%0d got=%b exp=1", i, bus_tvalid); end
         checks++; if (bus_tdata !== e[31:0]) begin failures++; $display("FAIL mid_data beat=%0d got=%h exp=%h", i, bus_tdata, e[31:0]); end
         checks++; if (bus_tlast !== (i == 3)) begin failures++; $display("FAIL mid_last beat=%0d got=%b exp=%b", i, bus_tlast, (i == 3)); end
         @(negedge clk);
      end
      #1;
      checks++; if (bus_tvalid !== 1'b0) begin failures++; $display("FAIL mid_leftover got=%b exp=0", bus_tvalid); end
   endtask

   task automatic test_width64();
      logic [127:0] e;
      @(negedge clk);
      w_bus_tready = 1'b1;
      w_blk_tvalid = 1'b1; w_blk_tdata = BLK_A; w_blk_tlast = 1'b1;
      #1;
      checks++; if (w_blk_tready !== 1'b1) begin failures++; $display("FAIL w64_accept got=%b exp=1", w_blk_tready); end
      @(negedge clk);
      w_blk_tvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         e = exp_beat(BLK_A, i, 64);
         checks++; if (w_bus_tvalid !== 1'b1) begin failures++; $display("FAIL w64_valid beat=%0d got=%b exp=1", i, w_bus_tvalid); end
         checks++; if (w_bus_tdata !== e[63:0]) begin failures++; $display("FAIL w64_data beat=%0d got=%h exp=%h", i, w_bus_tdata, e[63:0]); end
         checks++; if (w_bus_tlast !== (i == 1)) begin failures++; $display("FAIL w64_last beat=%0d got=%b exp=%b", i, w_bus_tlast, (i == 1)); end
         @(negedge clk);
      end
      #1;
      checks++; if (w_bus_tvalid !== 1'b0) begin failures++; $display("FAIL w64_idle got=%b exp=0", w_bus_tvalid); end
   endtask

   initial begin
      test_reset();
      test_single_block();
      test_backpressure();
      test_full_buffer();
      test_reset_mid_block();
      test_width64();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
